// File: rtl/phy_pkg.sv
// Shared definitions for the PHY lane receive path: FSM states, standard
// COM symbols and a constant-width helper.
package phy_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COM_8B  = 8'hBC;
  localparam logic [9:0] COM_10B = 10'h17C;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/phy_sp_align_if.sv
// Serial-in / parallel-out bus of the lane aligner. master = lane driver,
// slave = aligner.
interface phy_sp_align_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             realign;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;
  logic             com_seen;

  modport master (
    output data_in, realign,
    input  data_out, valid_out, active, com_seen
  );

  modport slave (
    input  data_in, realign,
    output data_out, valid_out, active, com_seen
  );
endinterface

// File: rtl/phy_sp_window.sv
// Sliding WIDTH-bit window over the serial stream (newest bit in the LSB)
// with a COM comparator; shared with the lane-deskew block.
module phy_sp_window
  import phy_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COM   = WIDTH'(COM_8B)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             data_in,
  output logic [WIDTH-1:0] win,
  output logic             win_is_com
);

  // Only WIDTH-1 history bits are stored; the current bit completes the window.
  logic [WIDTH-2:0] sr;

  assign win        = {sr, data_in};
  assign win_is_com = (win == COM);

  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= win[WIDTH-2:0];
  end

endmodule

// File: rtl/phy_sp_align.sv
// Serial-to-parallel receiver: bit-slip search for COM, N_COM aligned COMs
// to lock, then one parallel word per WIDTH cycles with COM treated as idle.
module phy_sp_align
  import phy_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COM   = WIDTH'(COM_8B),
  parameter int               N_COM = 4
) (
  input  logic          clk_8f,
  input  logic          reset,
  phy_sp_align_if.slave bus
);

  localparam int unsigned BCW = clog2(WIDTH);
  localparam int unsigned CCW = clog2(N_COM + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] COM_TARGET = CCW'(N_COM);

  state_t           state, state_n;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [CCW-1:0]   com_cnt, com_cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             valid_q, valid_n;
  logic             com_q, com_n;
  logic [WIDTH-1:0] win;
  logic             win_is_com;
  logic             clr;

  assign clr = !reset || bus.realign;

  phy_sp_window #(
    .WIDTH (WIDTH),
    .COM   (COM)
  ) u_window (
    .clk        (clk_8f),
    .clr        (clr),
    .data_in    (bus.data_in),
    .win        (win),
    .win_is_com (win_is_com)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    com_cnt_n = com_cnt;
    data_n    = data_q;
    valid_n   = 1'b0;
    com_n     = 1'b0;
    case (state)
      SEARCH: begin
        // Sliding compare; a hit defines the word boundary.
        bit_cnt_n = '0;
        if (win_is_com) begin
          com_n     = 1'b1;
          com_cnt_n = CCW'(1);
          state_n   = (N_COM == 1) ? ACTIVE : COUNT;
        end
      end
      COUNT: begin
        if (bit_cnt == LAST_BIT) begin
          if (win_is_com) begin
            com_n = 1'b1;
            if (com_cnt != COM_TARGET) com_cnt_n = com_cnt + 1'b1;
            if (com_cnt + 1'b1 == COM_TARGET) state_n = ACTIVE;
          end else begin
            state_n   = SEARCH;
            com_cnt_n = '0;
          end
        end
      end
      ACTIVE: begin
        if (bit_cnt == LAST_BIT) begin
          data_n  = win;
          valid_n = !win_is_com;
          com_n   = win_is_com;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state   <= SEARCH;
      bit_cnt <= '0;
      com_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      com_q   <= 1'b0;
    end else if (bus.realign) begin
      // Same as reset but the last delivered word stays visible.
      state   <= SEARCH;
      bit_cnt <= '0;
      com_cnt <= '0;
      valid_q <= 1'b0;
      com_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      com_cnt <= com_cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      com_q   <= com_n;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.com_seen  = com_q;
  assign bus.active    = (state == ACTIVE);

endmodule

// File: tb/tb_phy_sp_align.sv
// Directed bench for phy_sp_align: 8-bit/N_COM=4 instance driven from a word
// table plus hand sequences, and a 10-bit/N_COM=1 instance.
module tb_phy_sp_align;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  phy_sp_align_if #(.WIDTH(8))  bus_a ();
  phy_sp_align_if #(.WIDTH(10)) bus_b ();

  phy_sp_align u_a (
    .clk_8f (clk),
    .reset  (reset),
    .bus    (bus_a.slave)
  );

  phy_sp_align #(
    .WIDTH (10),
    .COM   (10'h17C),
    .N_COM (1)
  ) u_b (
    .clk_8f (clk),
    .reset  (reset),
    .bus    (bus_b.slave)
  );

  typedef struct {
    logic [7:0] word;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_com;
    logic       exp_active;
  } vec_t;

  vec_t vecs[18];
  int unsigned total  = 0;
  int unsigned passed = 0;

  function automatic vec_t mk(input logic [7:0] w, input logic ev, input logic [7:0] ed,
                              input logic ec, input logic ea);
    vec_t v;
    v.word = w; v.exp_valid = ev; v.exp_data = ed; v.exp_com = ec; v.exp_active = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bits_a(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_a.data_in = b[i];
      tick();
    end
  endtask

  task automatic send_a(input logic [7:0] w, input logic ev, input logic [7:0] ed,
                        input logic ec, input logic ea, input string tag);
    for (int i = 7; i >= 0; i--) begin
      bus_a.data_in = w[i];
      tick();
      if (i != 0)
        chk({tag, " mid strobes"}, {30'd0, bus_a.valid_out, bus_a.com_seen}, 32'd0);
    end
    chk({tag, " valid_out"}, 32'(bus_a.valid_out), 32'(ev));
    chk({tag, " data_out"},  32'(bus_a.data_out),  32'(ed));
    chk({tag, " com_seen"},  32'(bus_a.com_seen),  32'(ec));
    chk({tag, " active"},    32'(bus_a.active),    32'(ea));
  endtask

  task automatic send_b(input logic [9:0] w, input logic ev, input logic [9:0] ed,
                        input logic ec, input logic ea, input string tag);
    for (int i = 9; i >= 0; i--) begin
      bus_b.data_in = w[i];
      tick();
      if (i != 0)
        chk({tag, " mid strobes"}, {30'd0, bus_b.valid_out, bus_b.com_seen}, 32'd0);
    end
    chk({tag, " valid_out"}, 32'(bus_b.valid_out), 32'(ev));
    chk({tag, " data_out"},  32'(bus_b.data_out),  32'(ed));
    chk({tag, " com_seen"},  32'(bus_b.com_seen),  32'(ec));
    chk({tag, " active"},    32'(bus_b.active),    32'(ea));
  endtask

  task automatic chk_idle_a(input string tag, input logic [7:0] ed);
    chk({tag, " active"},    32'(bus_a.active),    32'd0);
    chk({tag, " valid_out"}, 32'(bus_a.valid_out), 32'd0);
    chk({tag, " com_seen"},  32'(bus_a.com_seen),  32'd0);
    chk({tag, " data_out"},  32'(bus_a.data_out),  32'(ed));
  endtask

  initial begin
    // lock with garbage prefix
    vecs[0]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[1]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[2]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[3]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b1);
    vecs[4]  = mk(8'h55, 1'b1, 8'h55, 1'b0, 1'b1);
    vecs[5]  = mk(8'hA3, 1'b1, 8'hA3, 1'b0, 1'b1);
    // broken COM run falls back to SEARCH
    vecs[6]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[7]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[8]  = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[9]  = mk(8'h12, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[10] = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[11] = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[12] = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[13] = mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b1);
    vecs[14] = mk(8'h34, 1'b1, 8'h34, 1'b0, 1'b1);
    // idle COM while active
    vecs[15] = mk(8'h01, 1'b1, 8'h01, 1'b0, 1'b1);
    vecs[16] = mk(8'hBC, 1'b0, 8'hBC, 1'b1, 1'b1);
    vecs[17] = mk(8'h02, 1'b1, 8'h02, 1'b0, 1'b1);

    reset = 1'b0;
    bus_a.data_in = 1'b0; bus_a.realign = 1'b0;
    bus_b.data_in = 1'b0; bus_b.realign = 1'b0;

    for (int c = 0; c < 3; c++) begin
      bus_a.data_in = c[0];
      bus_b.data_in = ~c[0];
      tick();
      chk_idle_a("reset hold", 8'h00);
      chk("reset hold b data_out", 32'(bus_b.data_out), 32'd0);
      chk("reset hold b active",   32'(bus_b.active),   32'd0);
    end
    reset = 1'b1;
    bus_a.data_in = 1'b0;
    bus_b.data_in = 1'b0;
    tick();
    chk_idle_a("reset release", 8'h00);

    bits_a(8'b101, 3);
    for (int k = 0; k <= 5; k++) send_a(vecs[k].word, vecs[k].exp_valid, vecs[k].exp_data,
                                        vecs[k].exp_com, vecs[k].exp_active, $sformatf("t2 v%0d", k));

    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_a("t3 reset", 8'h00);
    for (int k = 6; k <= 17; k++) send_a(vecs[k].word, vecs[k].exp_valid, vecs[k].exp_data,
                                         vecs[k].exp_com, vecs[k].exp_active, $sformatf("t34 v%0d", k));

    bits_a(8'b111, 3);
    bus_a.realign = 1'b1;
    bus_a.data_in = 1'b1;
    tick();
    bus_a.realign = 1'b0;
    chk_idle_a("realign", 8'h02);
    for (int k = 0; k < 3; k++) send_a(8'hBC, 1'b0, 8'h02, 1'b1, 1'b0, "realign com");
    send_a(8'hBC, 1'b0, 8'h02, 1'b1, 1'b1, "realign lock");
    send_a(8'h66, 1'b1, 8'h66, 1'b0, 1'b1, "realign word");

    bits_a(8'b10101, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_a("mid reset", 8'h00);
    for (int k = 0; k < 3; k++) send_a(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0, "reset com");
    send_a(8'hBC, 1'b0, 8'h00, 1'b1, 1'b1, "reset lock");
    send_a(8'h99, 1'b1, 8'h99, 1'b0, 1'b1, "reset word");

    bus_a.data_in = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      bus_b.data_in = i[0] ^ i[2];
      tick();
    end
    chk("w10 pre-lock active", 32'(bus_b.active), 32'd0);
    send_b(10'h17C, 1'b0, 10'h000, 1'b1, 1'b1, "w10 com");
    send_b(10'h2A5, 1'b1, 10'h2A5, 1'b0, 1'b1, "w10 word");
    send_b(10'h17C, 1'b0, 10'h17C, 1'b1, 1'b1, "w10 idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
